// File: rtl/zeroriscy_irq_arbiter_pkg.sv
// Shared definitions for the zeroriscy interrupt arbiter: source count, ID width
// and the request-presentation FSM states.
package zeroriscy_defines;

  localparam int NUM_IRQ  = 32;
  localparam int IRQ_ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic                valid;
    logic [IRQ_ID_W-1:0] id;
  } irq_ack_t;

endpackage

// File: rtl/zeroriscy_irq_arbiter_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins, index 0 highest priority.
module zeroriscy_irq_prio_enc
  import zeroriscy_defines::*;
(
  input  logic [NUM_IRQ-1:0]  req_i,
  output logic [IRQ_ID_W-1:0] id_o,
  output logic                valid_o
);

  always_comb begin
    id_o    = '0;
    valid_o = |req_i;
    // Walk downward so the last hit is the lowest index.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = i[IRQ_ID_W-1:0];
    end
  end

endmodule

// File: rtl/zeroriscy_irq_arbiter.sv
// Edge-captured, maskable interrupt arbiter presenting one registered level
// request plus ID to the zeroriscy core, with a one-cycle holdoff after ack.
module zeroriscy_irq_arbiter #(
  parameter int NUM_IRQ = zeroriscy_defines::NUM_IRQ
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_lines_i,
  input  logic                mask_we_i,
  input  logic [NUM_IRQ-1:0]  mask_wdata_i,
  output logic [NUM_IRQ-1:0]  mask_o,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic                irq_o,
  output logic [4:0]          irq_id_o,
  input  logic                irq_ack_i,
  input  logic [4:0]          irq_ack_id_i
);
  import zeroriscy_defines::*;

  irq_state_e          state_q;
  logic [NUM_IRQ-1:0]  line_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  mask_q;
  logic [NUM_IRQ-1:0]  line_rise;
  logic [NUM_IRQ-1:0]  ack_clr;
  logic                irq_q;
  logic [4:0]          irq_id_q;
  logic [4:0]          win_id;
  logic                win_vld;
  irq_ack_t            ack;

  assign ack.valid = irq_ack_i && (state_q == IRQ_ASSERT);
  assign ack.id    = irq_ack_id_i;

  always_comb begin
    line_rise = irq_lines_i & ~line_q;
    ack_clr   = '0;
    if (ack.valid) ack_clr[ack.id] = 1'b1;
    // New edge wins over a simultaneous ack clear of the same bit.
    pending_d = (pending_q & ~ack_clr) | line_rise;
  end

  zeroriscy_irq_prio_enc u_prio_enc (
    .req_i   (pending_q & mask_q),
    .id_o    (win_id),
    .valid_o (win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      line_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      line_q    <= irq_lines_i;
      pending_q <= pending_d;
      if (mask_we_i) mask_q <= mask_wdata_i;
      case (state_q)
        IRQ_IDLE: begin
          if (win_vld) begin
            irq_id_q <= win_id;
            irq_q    <= 1'b1;
            state_q  <= IRQ_ASSERT;
          end
        end
        IRQ_ASSERT: begin
          if (ack.valid) begin
            irq_q   <= 1'b0;
            state_q <= IRQ_HOLDOFF;
          end
        end
        IRQ_HOLDOFF: begin
          irq_q   <= 1'b0;
          state_q <= IRQ_IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IRQ_IDLE;
        end
      endcase
    end
  end

  assign mask_o    = mask_q;
  assign pending_o = pending_q;
  assign irq_o     = irq_q;
  assign irq_id_o  = irq_id_q;

endmodule

// File: doc/zeroriscy_irq_arbiter.md
ZERORISCY_IRQ_ARBITER -- requirements
Module: zeroriscy_irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt source lines; fixed at 32 for 5-bit IDs.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port irq_lines_i  input  32  external event lines; rising edge = event.
REQ-005 SHALL have port mask_we_i  input  1  mask write strobe.
REQ-006 SHALL have port mask_wdata_i  input  32  new mask value; 1 = enabled.
REQ-007 SHALL have port mask_o  output  32  current mask register.
REQ-008 SHALL have port pending_o  output  32  current pending register.
REQ-009 SHALL have port irq_o  output  1  level request to core irq_i.
REQ-010 SHALL have port irq_id_o  output  5  ID of presented interrupt, to core irq_id_i.
REQ-011 SHALL have port irq_ack_i  input  1  core has taken the interrupt (one-cycle pulse).
REQ-012 SHALL have port irq_ack_id_i  input  5  ID being acknowledged, valid with irq_ack_i.

Function
REQ-013 SHALL register irq_lines_i into line_q every cycle; edge[i] = irq_lines_i[i] & ~line_q[i].
REQ-014 SHALL set pending[i] at end of any cycle where edge[i]=1, regardless of mask.
REQ-015 SHALL select, among pending & mask, the lowest index as winner (index 0 highest priority).
REQ-016 SHALL implement FSM states IDLE, ASSERT, HOLDOFF.
REQ-017 IDLE: irq_o=0; if a winner exists, latch winner into irq_id_o and go ASSERT.
REQ-018 ASSERT: irq_o=1, irq_id_o frozen; on irq_ack_i clear pending[irq_ack_id_i], go HOLDOFF; else stay.
REQ-019 HOLDOFF: irq_o=0 for exactly one cycle, then IDLE (lets core controller return to its idle state without re-sampling a stale request).
REQ-020 SHALL drive irq_o and irq_id_o directly from registers (no combinational path from inputs).
REQ-021 Latency: edge in cycle N -> pending visible N+1 -> irq_o=1 in N+2 (line idle, mask set, FSM in IDLE).
REQ-022 Mask changes SHALL NOT withdraw an ASSERT in progress; masking affects arbitration only in IDLE.
REQ-023 Edge on bit i in same cycle as ack clearing bit i: set SHALL win (pending[i]=1 afterwards).
REQ-024 irq_ack_i in IDLE or HOLDOFF SHALL be ignored (no pending bit cleared).
REQ-025 Ack with irq_ack_id_i != irq_id_o SHALL clear pending[irq_ack_id_i] and still go HOLDOFF.
REQ-026 mask_we_i SHALL update mask at end of cycle; new mask used by arbitration from next cycle.
REQ-027 Repeated edges on an already-pending bit SHALL coalesce into one pending event.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, pending=0, mask=0, line_q=0, irq_o=0, irq_id_o=0.
REQ-029 Reset asserted mid-ASSERT SHALL drop irq_o to 0 the cycle after the reset edge; no pending state survives.
REQ-030 Line held high through reset deassertion SHALL register an edge in the first cycle after reset (line_q=0).

Structure
REQ-031 FSM state enum and NUM_IRQ constant SHALL live in the shared zeroriscy_defines package.
REQ-032 Winner selection SHALL be a sub-module zeroriscy_irq_prio_enc (32-bit request in, 5-bit ID + valid out, purely combinational).

Verification
REQ-033 Reset, mask=0xFFFF_FFFF, pulse line 5 at cycle N -> pending_o=0x20 at N+1, irq_o=1, irq_id_o=5 at N+2.
REQ-034 Lines 3 and 9 rise same cycle -> ID 3 presented; ack(3) -> one HOLDOFF cycle irq_o=0, then ID 9 presented.
REQ-035 mask=0, pulse line 7 -> pending_o=0x80, irq_o stays 0; write mask=0x80 -> irq_o=1, ID 7 two cycles after write.
REQ-036 In ASSERT with ID 2, line 2 rises again same cycle as ack(2) -> pending[2]=1 after; ID 2 re-presented after HOLDOFF.
REQ-037 ack pulse in IDLE with pending=0x10 -> pending unchanged 0x10; rst mid-ASSERT -> irq_o=0, pending_o=0, mask_o=0.
